// File: rtl/led_frame_buffer.sv
// led_frame_buffer
// Double-buffered 32x32 RGB frame store. 16-bit words (pixel writes and
// commands) land in the back bank. The front bank is streamed to the panel
// scanner as top/bottom pixel pairs. Bank swaps only take effect on the
// frame-end handshake so a displayed frame never mixes two images.
module led_frame_buffer #(
  parameter int COLS      = 32,
  parameter int HALF_ROWS = 16,
  parameter int COLOR_W   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [15:0]                  in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLOR_W-1:0]           out_rgb1,
  output logic [COLOR_W-1:0]           out_rgb2,
  output logic [$clog2(HALF_ROWS)-1:0] out_row,
  output logic [$clog2(COLS)-1:0]      out_col,
  output logic                         out_row_end,
  output logic                         out_frame_end,
  output logic                         swap_pending,
  output logic                         clearing
);

  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(HALF_ROWS);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam int DEPTH  = HALF_ROWS * COLS;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HALF_ROWS - 1);

  typedef enum logic [1:0] {
    INIT_CLEAR = 2'd0,
    IDLE       = 2'd1,
    CLEAR      = 2'd2,
    SWAP_WAIT  = 2'd3
  } state_t;

  // Four arrays indexed {bank, half}: bank 0/1, half 0 = top rows, 1 = bottom rows.
  logic [COLOR_W-1:0] mem_r [0:3][0:DEPTH-1];

  state_t              state_r;
  logic [ADDR_W-1:0]   clr_cnt_r;
  logic                front_r;

  logic                in_hs_s;
  logic                out_hs_s;
  logic                swap_fire_s;
  logic                rd_bank_s;
  logic                load_s;
  logic [ROW_W-1:0]    rd_row_s;
  logic [COL_W-1:0]    rd_col_s;
  logic [ADDR_W-1:0]   rd_addr_s;
  logic                pix_half_s;
  logic [ROW_W-1:0]    pix_row_s;
  logic [COL_W-1:0]    pix_x_s;
  logic [3:0]          wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [COLOR_W-1:0]  wr_data_s;
  logic                unused_bits_s;

  assign in_hs_s     = in_valid && in_ready;
  assign out_hs_s    = out_valid && out_ready;
  // The bank flips on the frame-end handshake, and the pair fetched on that
  // same edge (row 0, col 0) must already come from the new front bank.
  assign swap_fire_s = (state_r == SWAP_WAIT) && out_hs_s && out_frame_end;
  assign rd_bank_s   = front_r ^ swap_fire_s;
  // First fetch after the power-up clear, then one fetch per handshake.
  assign load_s      = out_valid ? out_ready : (state_r != INIT_CLEAR);
  assign rd_addr_s   = {rd_row_s, rd_col_s};

  assign pix_x_s       = in_data[10 +: COL_W];
  assign pix_row_s     = in_data[5 +: ROW_W];
  assign pix_half_s    = in_data[5 + ROW_W];
  assign unused_bits_s = ^in_data[4:3];

  // Next scan position: hold (0,0) before the first pair, else advance with wrap.
  always_comb begin
    rd_row_s = out_row;
    rd_col_s = out_col;
    if (!out_valid) begin
      rd_row_s = out_row;
      rd_col_s = out_col;
    end else if (out_col == LAST_COL) begin
      rd_col_s = {COL_W{1'b0}};
      rd_row_s = (out_row == LAST_ROW) ? {ROW_W{1'b0}} : out_row + ROW_W'(1);
    end else begin
      rd_col_s = out_col + COL_W'(1);
      rd_row_s = out_row;
    end
  end

  // Write port select: clears sweep an address per cycle, pixel writes hit one back-bank half.
  always_comb begin
    wr_en_s   = 4'b0000;
    wr_addr_s = clr_cnt_r;
    wr_data_s = {COLOR_W{1'b0}};
    case (state_r)
      INIT_CLEAR: wr_en_s = 4'b1111;
      CLEAR:      wr_en_s = front_r ? 4'b0011 : 4'b1100;
      IDLE: begin
        if (in_hs_s && !in_data[15]) begin
          wr_en_s[{~front_r, pix_half_s}] = 1'b1;
          wr_addr_s = {pix_row_s, pix_x_s};
          wr_data_s = in_data[COLOR_W-1:0];
        end else begin
          wr_en_s = 4'b0000;
        end
      end
      default: wr_en_s = 4'b0000;
    endcase
  end

  // Frame store write port; contents are re-zeroed by INIT_CLEAR, so no reset here.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en_s[b]) begin
        mem_r[b][wr_addr_s] <= wr_data_s;
      end
    end
  end

  // Control FSM: clear sequencing, command decode and frame-aligned bank swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= INIT_CLEAR;
      clr_cnt_r    <= {ADDR_W{1'b0}};
      front_r      <= 1'b0;
      in_ready     <= 1'b0;
      swap_pending <= 1'b0;
      clearing     <= 1'b1;
    end else begin
      case (state_r)
        INIT_CLEAR, CLEAR: begin
          if (clr_cnt_r == LAST_ADDR) begin
            state_r   <= IDLE;
            clr_cnt_r <= {ADDR_W{1'b0}};
            in_ready  <= 1'b1;
            clearing  <= 1'b0;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (in_hs_s && in_data[15]) begin
            case (in_data[1:0])
              2'b01: begin
                state_r      <= SWAP_WAIT;
                in_ready     <= 1'b0;
                swap_pending <= 1'b1;
              end
              2'b10: begin
                state_r   <= CLEAR;
                in_ready  <= 1'b0;
                clearing  <= 1'b1;
                clr_cnt_r <= {ADDR_W{1'b0}};
              end
              default: state_r <= IDLE;
            endcase
          end
        end
        SWAP_WAIT: begin
          if (swap_fire_s) begin
            front_r      <= ~front_r;
            state_r      <= IDLE;
            in_ready     <= 1'b1;
            swap_pending <= 1'b0;
          end
        end
        default: begin
          state_r   <= INIT_CLEAR;
          clr_cnt_r <= {ADDR_W{1'b0}};
          in_ready  <= 1'b0;
          clearing  <= 1'b1;
        end
      endcase
    end
  end

  // Scan output stage: synchronous front-bank read straight into the pair registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_row       <= {ROW_W{1'b0}};
      out_col       <= {COL_W{1'b0}};
      out_rgb1      <= {COLOR_W{1'b0}};
      out_rgb2      <= {COLOR_W{1'b0}};
      out_row_end   <= 1'b0;
      out_frame_end <= 1'b0;
    end else if (load_s) begin
      out_valid     <= 1'b1;
      out_row       <= rd_row_s;
      out_col       <= rd_col_s;
      out_rgb1      <= mem_r[{rd_bank_s, 1'b0}][rd_addr_s];
      out_rgb2      <= mem_r[{rd_bank_s, 1'b1}][rd_addr_s];
      out_row_end   <= (rd_col_s == LAST_COL);
      out_frame_end <= (rd_col_s == LAST_COL) && (rd_row_s == LAST_ROW);
    end
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Bench for led_frame_buffer: the stimulus keeps a two-bank image model and
// pushes the expected pixel pairs of every frame it expects to be shown; a
// monitor pops one entry per output handshake and compares.
module tb_led_frame_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_rgb1;
  logic [2:0]  out_rgb2;
  logic [3:0]  out_row;
  logic [4:0]  out_col;
  logic        out_row_end;
  logic        out_frame_end;
  logic        swap_pending;
  logic        clearing;

  int          total = 0;
  int          passes = 0;
  logic [16:0] exp_q[$];
  logic [2:0]  img [0:1][0:1023];
  logic        fb;

  localparam logic [15:0] CMD_NOP   = 16'h8003;
  localparam logic [15:0] CMD_SWAP  = 16'h8001;
  localparam logic [15:0] CMD_CLEAR = 16'h8002;

  led_frame_buffer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_rgb1(out_rgb1), .out_rgb2(out_rgb2), .out_row(out_row), .out_col(out_col),
    .out_row_end(out_row_end), .out_frame_end(out_frame_end),
    .swap_pending(swap_pending), .clearing(clearing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [16:0] cur_pair();
    return {out_row, out_col, out_rgb1, out_rgb2, out_row_end, out_frame_end};
  endfunction

  // Monitor: every output handshake consumes one expected pair.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("pair_underflow", 32'(exp_q.size()), 32'd1);
      else check("pair", 32'(cur_pair()), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 1024; i++) img[b][i] = 3'd0;
    fb = 1'b0;
  endtask

  task automatic push_frame();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++)
        exp_q.push_back({r[3:0], c[4:0], img[fb][r*32+c], img[fb][(r+16)*32+c],
                         (c == 31), (r == 15 && c == 31)});
  endtask

  task automatic send_word(input logic [15:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic write_px(input int x, input int y, input logic [2:0] rgb);
    logic [15:0] w;
    w = {1'b0, x[4:0], y[4:0], 2'b00, rgb};
    img[~fb][y*32+x] = rgb;
    send_word(w);
  endtask

  // Stall the scanner inside the last pushed frame, so a swap lands at its end.
  task automatic stall_mid();
    int n = 0;
    @(posedge clk);
    #1;
    while (exp_q.size() > 300 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_reach", 32'(exp_q.size() <= 300), 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    int n = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check({tag, "_reset_vals"},
          32'({out_valid, in_ready, clearing, swap_pending, cur_pair()}),
          32'({1'b0, 1'b0, 1'b1, 1'b0, 17'd0}));
    while (clearing && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd512);
    check({tag, "_ready_after_init"}, 32'({in_ready, swap_pending}), 32'b10);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    model_reset();

    // Power-up clear, then two all-zero frames with full row/col sequencing.
    do_reset("t1");
    push_frame();
    push_frame();
    @(posedge clk);
    #1;

    // One bottom-half pixel, a reserved NOP, then a swap.
    stall_mid();
    write_px(3, 20, 3'b101);
    send_word(CMD_NOP);
    send_word(CMD_SWAP);
    fb = ~fb;
    push_frame();
    out_ready = 1'b1;

    // Swap requested while the scanner is stalled for 100 cycles.
    stall_mid();
    write_px(0, 0, 3'b111);
    write_px(31, 31, 3'b011);
    write_px(31, 15, 3'b110);
    send_word(CMD_SWAP);
    @(negedge clk);
    check("t3_pending", 32'({swap_pending, in_ready}), 32'b10);
    repeat (100) @(negedge clk);
    check("t3_hold_pair", 32'(cur_pair()), 32'(exp_q[0]));
    check("t3_hold_flags", 32'({out_valid, swap_pending, in_ready}), 32'b110);
    fb = ~fb;
    push_frame();
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Swap, then clear the new back bank while the front keeps showing.
    stall_mid();
    write_px(10, 16, 3'b010);
    send_word(CMD_SWAP);
    fb = ~fb;
    push_frame();
    push_frame();
    out_ready = 1'b1;
    send_word(CMD_CLEAR);
    for (int i = 0; i < 1024; i++) img[~fb][i] = 3'd0;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("t4_clear_cycles", 32'(n), 32'd512);
    stall_mid();
    send_word(CMD_SWAP);
    fb = ~fb;
    push_frame();
    out_ready = 1'b1;

    // Three frames under a random out_ready.
    stall_mid();
    write_px(5, 1, 3'b100);
    write_px(6, 17, 3'b001);
    write_px(0, 15, 3'b111);
    send_word(CMD_SWAP);
    fb = ~fb;
    push_frame();
    push_frame();
    push_frame();
    n = 0;
    while (exp_q.size() > 0 && n < 20000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    check("t5_drain", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a clear.
    send_word(CMD_CLEAR);
    repeat (100) @(negedge clk);
    check("t6_mid_clear", 32'({clearing, in_ready}), 32'b10);
    @(posedge clk);
    #1;
    do_reset("t6a");
    model_reset();

    // Reset while a swap is pending; the swap is dropped.
    @(posedge clk);
    #1;
    write_px(4, 5, 3'b011);
    send_word(CMD_SWAP);
    @(negedge clk);
    check("t6_swap_wait", 32'({swap_pending, in_ready}), 32'b10);
    @(posedge clk);
    #1;
    do_reset("t6b");
    model_reset();
    push_frame();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("t6");
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
